// File: rtl/tt_autosel_pkg.sv
// rtl/tt_autosel_pkg.sv - shared types and default constants for the autosel mux path
package tt_autosel_pkg;

    // ADDR_W is also used by the EEPROM reader to extract the address field
    localparam int DEF_ADDR_W       = 10;
    localparam int DEF_RST_CYCLES   = 8;
    localparam int DEF_PULSE_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        GAP,
        INC_HI,
        INC_LO,
        FINISH
    } state_t;

endpackage

// File: rtl/tt_mux_sel_sequencer.sv
// rtl/tt_mux_sel_sequencer.sv - drives TinyTapeout mux reset, N increment pulses, then enable
module tt_mux_sel_sequencer
    import tt_autosel_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] sel_addr,
    input  logic              ena_req,
    output logic              busy,
    output logic              done,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    localparam int MAX_CYCLES = (RST_CYCLES > PULSE_CYCLES) ? RST_CYCLES : PULSE_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);

    localparam logic [TIMER_W-1:0] RST_LOAD   = TIMER_W'(RST_CYCLES);
    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);

    state_t              state;
    logic [TIMER_W-1:0]  timer;
    logic [ADDR_W-1:0]   remaining;
    logic                ena_lat;
    logic                timer_last;

    assign timer_last = (timer == TIMER_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            timer          <= '0;
            remaining      <= '0;
            ena_lat        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    ctrl_sel_rst_n <= 1'b1;
                    ctrl_sel_inc   <= 1'b0;
                    if (start) begin
                        remaining      <= sel_addr;
                        ena_lat        <= ena_req;
                        ctrl_ena       <= 1'b0;
                        ctrl_sel_rst_n <= 1'b0;
                        timer          <= RST_LOAD;
                        busy           <= 1'b1;
                        state          <= RST;
                    end
                end
                RST: begin
                    if (timer_last) begin
                        ctrl_sel_rst_n <= 1'b1;
                        timer          <= PULSE_LOAD;
                        state          <= GAP;
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end
                GAP: begin
                    if (timer_last) begin
                        timer <= PULSE_LOAD;
                        if (remaining != '0) begin
                            ctrl_sel_inc <= 1'b1;
                            state        <= INC_HI;
                        end else begin
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            ctrl_ena <= ena_lat;
                            state    <= FINISH;
                        end
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end
                INC_HI: begin
                    if (timer_last) begin
                        ctrl_sel_inc <= 1'b0;
                        timer        <= PULSE_LOAD;
                        state        <= INC_LO;
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end
                INC_LO: begin
                    if (timer_last) begin
                        // remaining is post-decrement > 0 exactly when it is currently > 1
                        if (remaining != '0) begin
                            remaining <= remaining - ADDR_ONE;
                        end
                        timer <= PULSE_LOAD;
                        if (remaining > ADDR_ONE) begin
                            ctrl_sel_inc <= 1'b1;
                            state        <= INC_HI;
                        end else begin
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            ctrl_ena <= ena_lat;
                            state    <= FINISH;
                        end
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_mux_sel_sequencer.sv
// tb/tb_tt_mux_sel_sequencer.sv - self-checking bench for tt_mux_sel_sequencer
module tb_tt_mux_sel_sequencer;
    import tt_autosel_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int RC = 8;
    localparam int PC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] sel_addr;
    logic          ena_req;
    logic          busy, done, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;

    tt_mux_sel_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .sel_addr       (sel_addr),
        .ena_req        (ena_req),
        .busy           (busy),
        .done           (done),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          ena;
        int            base;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          ena;
        int            exp_pulses;
        int            exp_done;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[6];

    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   pulse_cnt = 0;
    logic prev_inc = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: counts inc rising edges and scores each done pulse
    always @(negedge clk) begin
        if (ctrl_sel_inc === 1'b1 && prev_inc === 1'b0) pulse_cnt++;
        prev_inc = ctrl_sel_inc;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_count", pulse_cnt, mon_e.addr);
                check("done_cycle", edge_cnt - mon_e.base, 1 + RC + PC + 2 * PC * int'(mon_e.addr));
                check("ctrl_ena_at_done", ctrl_ena, mon_e.ena);
                check("busy_at_done", busy, 0);
            end
            pulse_cnt = 0;
        end else if (busy !== 1'b1) begin
            pulse_cnt = 0;
        end
    end

    task automatic start_seq(input logic [AW-1:0] a, input logic e, output int base);
        sel_addr = a;
        ena_req  = e;
        start    = 1'b1;
        base     = edge_cnt;
        sb.push_back('{a, e, base});
        @(negedge clk);
        start    = 1'b0;
        sel_addr = AW'($urandom);
        ena_req  = ~e;
        check("rst_n_low_cycle1", ctrl_sel_rst_n, 0);
        check("busy_cycle1", busy, 1);
        check("ena_clear_cycle1", ctrl_ena, 0);
    endtask

    task automatic wait_done(input int bound, input int base, input bit wave);
        int k;
        bit found;
        found = 1'b0;
        for (int n = 0; n < bound && !found; n++) begin
            if (done === 1'b1) begin
                found = 1'b1;
            end else begin
                check("busy_during_seq", busy, 1);
                if (wave) begin
                    k = edge_cnt - base;
                    check("rst_n_wave", ctrl_sel_rst_n, (k >= 1 && k <= 8) ? 0 : 1);
                    check("inc_wave", ctrl_sel_inc,
                          ((k >= 13 && k <= 16) || (k >= 21 && k <= 24) || (k >= 29 && k <= 32)) ? 1 : 0);
                end
                @(negedge clk);
            end
        end
        if (!found) check("done_timeout", 0, 1);
    endtask

    initial begin
        int base;
        logic [AW-1:0] ra;
        logic re;

        rst = 1'b1; start = 1'b0; sel_addr = '0; ena_req = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rst_n", ctrl_sel_rst_n, 0);
        check("reset_inc", ctrl_sel_inc, 0);
        check("reset_ena", ctrl_ena, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_n_after_release", ctrl_sel_rst_n, 1);
        check("busy_idle", busy, 0);

        vecs[0] = '{10'd3,    1'b1, 3,    37};
        vecs[1] = '{10'd0,    1'b1, 0,    13};
        vecs[2] = '{10'd1,    1'b0, 1,    21};
        vecs[3] = '{10'd5,    1'b1, 5,    53};
        vecs[4] = '{10'd2,    1'b0, 2,    29};
        vecs[5] = '{10'd1023, 1'b1, 1023, 8197};

        for (int i = 0; i < 6; i++) begin
            start_seq(vecs[i].addr, vecs[i].ena, base);
            wait_done(vecs[i].exp_done + 5, base, i == 0);
            check("table_done_cycle", edge_cnt - base, vecs[i].exp_done);
            check("table_ena_at_done", ctrl_ena, vecs[i].ena);
            @(negedge clk);
            check("table_idle_busy", busy, 0);
            check("table_idle_done", done, 0);
            check("table_ena_hold", ctrl_ena, vecs[i].ena);
        end

        // Restarts while busy and during FINISH must be ignored
        start_seq(10'd3, 1'b1, base);
        repeat (4) @(negedge clk);
        sel_addr = 10'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        sel_addr = 10'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, base, 1'b0);
        sel_addr = 10'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("finish_start_ignored_busy", busy, 0);
        check("finish_start_ignored_rst_n", ctrl_sel_rst_n, 1);
        @(negedge clk);
        check("finish_start_ignored_busy2", busy, 0);

        // Abort during the second INC_HI
        start_seq(10'd3, 1'b1, base);
        while (edge_cnt - base < 21) @(negedge clk);
        check("abort_inc_high_before", ctrl_sel_inc, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_inc", ctrl_sel_inc, 0);
        check("abort_rst_n", ctrl_sel_rst_n, 0);
        check("abort_ena", ctrl_ena, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
        check("abort_release_rst_n", ctrl_sel_rst_n, 1);
        start_seq(10'd2, 1'b1, base);
        wait_done(40, base, 1'b0);
        @(negedge clk);

        // Reset wins over a simultaneous start
        rst = 1'b1; start = 1'b1; sel_addr = 10'd5;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", busy, 0);
        check("rst_start_rst_n", ctrl_sel_rst_n, 0);
        @(negedge clk);
        check("rst_start_busy2", busy, 0);
        check("rst_start_rst_n2", ctrl_sel_rst_n, 1);

        for (int i = 0; i < 4; i++) begin
            ra = AW'($urandom_range(1, 200));
            re = 1'($urandom_range(0, 1));
            start_seq(ra, re, base);
            wait_done(1 + RC + PC + 2 * PC * int'(ra) + 5, base, 1'b0);
            @(negedge clk);
            check("rand_ena_hold", ctrl_ena, re);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
